// File: rtl/xif_copro_pkg.sv
// xif_copro_pkg: shared constants, ALU op encoding and tracking entry layout
// Entry field widths are fixed here; the tracker's width parameters must keep their defaults.
package xif_copro_pkg;
    localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_XOR = 3'd1;
    localparam logic [2:0] F3_SUB = 3'd2;
    localparam int ID_W   = 4;
    localparam int HART_W = 1;
    localparam int RF_W   = 32;

    typedef enum logic [1:0] {OP_ADD, OP_XOR, OP_SUB} alu_op_e;

    typedef struct packed {
        logic [HART_W-1:0]      hartid;
        logic [ID_W-1:0]        id;
        logic [4:0]             rd;
        alu_op_e                op;
        logic [1:0][RF_W-1:0]   rs;
        logic [1:0]             rs_valid;
        logic                   committed;
        logic                   killed;
    } entry_t;

    function automatic logic [RF_W-1:0] alu(alu_op_e op, logic [RF_W-1:0] a, logic [RF_W-1:0] b);
        return op == OP_XOR ? a ^ b : op == OP_SUB ? a - b : a + b;
    endfunction
endpackage

// File: rtl/xif_copro_decoder.sv
// xif_copro_decoder: combinational custom-0 decode into accept flag and ALU op
// Ports: opcode, funct3 in; accept, op out.
// XIF_COPRO_SUB_EN: when defined, funct3 SUB is accepted as well.
module xif_copro_decoder
    import xif_copro_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic       accept,
    output alu_op_e    op
);
`ifdef XIF_COPRO_SUB_EN
    assign accept = opcode == OPC_CUSTOM0 && (funct3 == F3_ADD || funct3 == F3_XOR || funct3 == F3_SUB);
`else
    assign accept = opcode == OPC_CUSTOM0 && (funct3 == F3_ADD || funct3 == F3_XOR);
`endif
    assign op = funct3 == F3_XOR ? OP_XOR : funct3 == F3_SUB ? OP_SUB : OP_ADD;
endmodule

// File: rtl/xif_copro_tracker.sv
// xif_copro_tracker: CV-X-IF coprocessor endpoint with in-order tracking table and registered result
// Ports: clk_i/rst_i; issue_* (request/response), register_* (operands), commit_* (commit/kill),
// result_* (registered result with valid/ready).
// XIF_COPRO_SUB_EN: enables the SUB instruction in the decoder.
module xif_copro_tracker
    import xif_copro_pkg::*;
#(
    parameter int X_ID_WIDTH     = ID_W,
    parameter int X_HARTID_WIDTH = HART_W,
    parameter int X_RFR_WIDTH    = RF_W,
    parameter int X_RFW_WIDTH    = RF_W,
    parameter int DEPTH          = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               issue_instr_i,
    input  logic [X_HARTID_WIDTH-1:0] issue_hartid_i,
    input  logic [X_ID_WIDTH-1:0]     issue_id_i,
    output logic                      issue_accept_o,
    output logic                      issue_writeback_o,
    output logic [1:0]                issue_register_read_o,
    output logic                      issue_ecswrite_o,
    output logic                      issue_loadstore_o,
    input  logic                      register_valid_i,
    output logic                      register_ready_o,
    input  logic [X_ID_WIDTH-1:0]     register_id_i,
    input  logic [2*X_RFR_WIDTH-1:0]  register_rs_i,
    input  logic [1:0]                register_rs_valid_i,
    input  logic                      commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]     commit_id_i,
    input  logic                      commit_kill_i,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic [X_HARTID_WIDTH-1:0] result_hartid_o,
    output logic [X_ID_WIDTH-1:0]     result_id_o,
    output logic [X_RFW_WIDTH-1:0]    result_data_o,
    output logic [4:0]                result_rd_o,
    output logic                      result_we_o,
    output logic                      result_exc_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t               tab [DEPTH];
    entry_t               hd;
    logic [PW-1:0]        head, tail;
    logic [CW-1:0]        count;
    logic [DEPTH-1:0]     live, rmatch, cmatch;
    logic                 dec_accept, alloc, ret, pop, hc, hk, hr;
    logic [1:0]           hv;
    logic [X_RFR_WIDTH-1:0] a, b;
    alu_op_e              dec_op;
    logic                 unused;

    assign unused = ^issue_instr_i[31:15];

    xif_copro_decoder u_dec (
        .opcode (issue_instr_i[6:0]),
        .funct3 (issue_instr_i[14:12]),
        .accept (dec_accept),
        .op     (dec_op)
    );

    assign issue_ready_o         = count != CW'(DEPTH);
    assign issue_accept_o        = dec_accept;
    assign issue_writeback_o     = dec_accept;
    assign issue_register_read_o = {2{dec_accept}};
    assign issue_ecswrite_o      = 1'b0;
    assign issue_loadstore_o     = 1'b0;
    assign register_ready_o      = 1'b1;
    assign result_we_o           = result_valid_o;
    assign result_exc_o          = 1'b0;
    assign alloc                 = issue_valid_i && issue_ready_o && dec_accept;

    // An entry is live when its distance from head is below the occupancy count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PW-1:0] off;
        assign off       = PW'(i) - head;
        assign live[i]   = {1'b0, off} < count;
        assign rmatch[i] = live[i] && register_valid_i && tab[i].id == register_id_i;
        assign cmatch[i] = live[i] && commit_valid_i && tab[i].id == commit_id_i;
    end

    // Head view merges this cycle's operand/commit traffic so a result can issue one cycle after it.
    assign hd  = tab[head];
    assign hr  = rmatch[head];
    assign hv  = hd.rs_valid | (hr ? register_rs_valid_i : 2'b00);
    assign a   = hr && register_rs_valid_i[0] ? register_rs_i[X_RFR_WIDTH-1:0] : hd.rs[0];
    assign b   = hr && register_rs_valid_i[1] ? register_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH] : hd.rs[1];
    assign hc  = hd.committed | cmatch[head];
    assign hk  = hd.killed | (cmatch[head] & commit_kill_i);
    assign ret = live[head] && hc && !hk && &hv && (!result_valid_o || result_ready_i);
    // A kill only frees the head once it is registered.
    assign pop = ret || (live[head] && hd.killed);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            result_valid_o  <= 1'b0;
            result_hartid_o <= '0;
            result_id_o     <= '0;
            result_data_o   <= '0;
            result_rd_o     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rmatch[i]) begin
                    tab[i].rs_valid <= tab[i].rs_valid | register_rs_valid_i;
                    if (register_rs_valid_i[0]) tab[i].rs[0] <= register_rs_i[X_RFR_WIDTH-1:0];
                    if (register_rs_valid_i[1]) tab[i].rs[1] <= register_rs_i[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
                end
                if (cmatch[i]) begin
                    tab[i].committed <= 1'b1;
                    if (commit_kill_i) tab[i].killed <= 1'b1;
                end
                if (alloc && tail == PW'(i))
                    tab[i] <= '{hartid: issue_hartid_i, id: issue_id_i, rd: issue_instr_i[11:7], op: dec_op,
                                rs: '0, rs_valid: 2'b00, committed: 1'b0, killed: 1'b0};
            end
            head  <= head + PW'(pop);
            tail  <= tail + PW'(alloc);
            count <= count + CW'(alloc) - CW'(pop);
            if (ret) begin
                result_valid_o  <= 1'b1;
                result_hartid_o <= hd.hartid;
                result_id_o     <= hd.id;
                result_rd_o     <= hd.rd;
                result_data_o   <= alu(hd.op, a, b);
            end else if (result_ready_i) begin
                result_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_xif_copro_tracker.sv
// tb_xif_copro_tracker: scoreboard bench with directed scenarios and randomized batches
module tb_xif_copro_tracker;
`ifdef XIF_COPRO_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam logic [6:0] OPC = 7'b0001011;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        issue_valid_i = 1'b0, issue_ready_o;
    logic [31:0] issue_instr_i = '0;
    logic        issue_hartid_i = 1'b0;
    logic [3:0]  issue_id_i = '0;
    logic        issue_accept_o, issue_writeback_o, issue_ecswrite_o, issue_loadstore_o;
    logic [1:0]  issue_register_read_o;
    logic        register_valid_i = 1'b0, register_ready_o;
    logic [3:0]  register_id_i = '0;
    logic [63:0] register_rs_i = '0;
    logic [1:0]  register_rs_valid_i = '0;
    logic        commit_valid_i = 1'b0, commit_kill_i = 1'b0;
    logic [3:0]  commit_id_i = '0;
    logic        result_valid_o, result_ready_i = 1'b1, result_hartid_o, result_we_o, result_exc_o;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;

    xif_copro_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_instr_i(issue_instr_i),
        .issue_hartid_i(issue_hartid_i), .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o),
        .issue_writeback_o(issue_writeback_o), .issue_register_read_o(issue_register_read_o),
        .issue_ecswrite_o(issue_ecswrite_o), .issue_loadstore_o(issue_loadstore_o),
        .register_valid_i(register_valid_i), .register_ready_o(register_ready_o),
        .register_id_i(register_id_i), .register_rs_i(register_rs_i), .register_rs_valid_i(register_rs_valid_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_hartid_o(result_hartid_o),
        .result_id_o(result_id_o), .result_data_o(result_data_o), .result_rd_o(result_rd_o),
        .result_we_o(result_we_o), .result_exc_o(result_exc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [3:0] id; logic [4:0] rd; logic [31:0] data; logic hart; } exp_t;
    typedef struct { logic [3:0] id; logic [1:0] mask; logic [31:0] a; logic [31:0] b; } reg_t;
    typedef struct { logic [3:0] id; logic kill; } com_t;
    typedef struct { logic [3:0] id; logic [31:0] a; logic [31:0] b; logic kill; } item_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    int   rr_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
        return {7'h0, 5'd2, 5'd1, f3, rd, opc};
    endfunction

    function automatic bit ref_acc(input logic [31:0] ins);
        return ins[6:0] == OPC && (ins[14:12] == 3'd0 || ins[14:12] == 3'd1 || (SUB_EN && ins[14:12] == 3'd2));
    endfunction

    function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3 == 3'd0 ? a + b : f3 == 3'd1 ? a ^ b : a - b;
    endfunction

    task automatic cyc();
        @(posedge clk_i); #1;
        issue_valid_i = 1'b0; register_valid_i = 1'b0; commit_valid_i = 1'b0;
    endtask

    task automatic do_issue(input logic [31:0] ins, input logic [3:0] id, input logic hart,
                            input logic [31:0] a, input logic [31:0] b, input bit kill, output bit acc);
        exp_t e;
        issue_valid_i = 1'b1; issue_instr_i = ins; issue_id_i = id; issue_hartid_i = hart;
        #1;
        acc = ref_acc(ins);
        chk("issue_accept", issue_accept_o, acc);
        chk("issue_writeback", issue_writeback_o, acc);
        chk("issue_register_read", issue_register_read_o, {2{acc}});
        chk("issue_ecs_ls", {issue_ecswrite_o, issue_loadstore_o}, 0);
        if (acc && !kill) begin
            e.id = id; e.rd = ins[11:7]; e.data = ref_calc(ins[14:12], a, b); e.hart = hart;
            exp_q.push_back(e);
        end
    endtask

    task automatic set_reg(input logic [3:0] id, input logic [1:0] mask, input logic [31:0] a, input logic [31:0] b);
        register_valid_i = 1'b1; register_id_i = id; register_rs_valid_i = mask;
        register_rs_i = {mask[1] ? b : $urandom, mask[0] ? a : $urandom};
    endtask

    task automatic set_com(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    endtask

    task automatic wait_drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin cyc(); n++; end
        chk(nm, exp_q.size(), 0);
        repeat (6) cyc();
    endtask

    initial forever begin
        @(posedge clk_i); #1;
        result_ready_i = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'($urandom % 2) : 1'b0;
    end

    // Monitor: pops the scoreboard on each result handshake and checks hold stability under backpressure.
    initial begin
        bit hold = 0;
        logic [41:0] held = '0;
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i) hold = 0;
            else begin
                if (hold) begin
                    chk("hold_valid", result_valid_o, 1);
                    chk("hold_fields", {result_hartid_o, result_id_o, result_rd_o, result_data_o}, held);
                end
                if (result_valid_o && result_ready_i) begin
                    hold = 0;
                    if (exp_q.size() == 0) chk("unexpected_result_id", result_id_o, 5'h10);
                    else begin
                        e = exp_q.pop_front();
                        chk("result_id", result_id_o, e.id);
                        chk("result_rd", result_rd_o, e.rd);
                        chk("result_data", result_data_o, e.data);
                        chk("result_hart", result_hartid_o, e.hart);
                        chk("result_we_exc", {result_we_o, result_exc_o}, 2'b10);
                    end
                end else if (result_valid_o) begin
                    hold = 1;
                    held = {result_hartid_o, result_id_o, result_rd_o, result_data_o};
                end else hold = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        logic [3:0] nid;
        item_t items[$];
        reg_t rq[$];
        com_t cq[$];
        item_t it;
        reg_t r;
        com_t c;
        logic [31:0] ins;

        repeat (2) cyc();
        rst_i = 1'b0;
        #1;
        chk("reset_valid_we", {result_valid_o, result_we_o}, 0);
        chk("reset_fields", {result_hartid_o, result_id_o, result_rd_o, result_data_o}, 0);
        chk("reset_ready", {issue_ready_o, register_ready_o}, 2'b11);

        // ADD: result one cycle after commit
        do_issue(mk(3'd0, 5'd5, OPC), 4'd3, 1'b0, 32'd10, 32'd20, 0, acc); cyc();
        set_reg(4'd3, 2'b11, 32'd10, 32'd20); cyc();
        set_com(4'd3, 1'b0); #1;
        chk("add_valid_early", result_valid_o, 0);
        cyc(); #1;
        chk("add_valid_latency", result_valid_o, 1);
        wait_drain("add_drain");

        // XOR: commit first, result one cycle after operands
        do_issue(mk(3'd1, 5'd6, OPC), 4'd4, 1'b1, 32'hF0F0, 32'h0FF0, 0, acc); cyc();
        set_com(4'd4, 1'b0); cyc(); cyc();
        set_reg(4'd4, 2'b11, 32'hF0F0, 32'h0FF0); #1;
        chk("xor_valid_early", result_valid_o, 0);
        cyc(); #1;
        chk("xor_valid_latency", result_valid_o, 1);
        wait_drain("xor_drain");

        // Full table, rejected instruction does not allocate
        for (int k = 5; k < 8; k++) begin do_issue(mk(3'd0, 5'(k), OPC), 4'(k), 1'b0, 32'(k), 32'(k * 3), 0, acc); cyc(); end
        do_issue(mk(SUB_EN ? 3'd3 : 3'd2, 5'd8, OPC), 4'd8, 1'b0, 0, 0, 0, acc); cyc(); #1;
        chk("reject_no_alloc_ready", issue_ready_o, 1);
        do_issue(mk(3'd1, 5'd9, OPC), 4'd9, 1'b0, 32'd9, 32'd27, 0, acc); cyc(); #1;
        chk("full_ready", issue_ready_o, 0);
        set_reg(4'd5, 2'b11, 32'd5, 32'd15); set_com(4'd5, 1'b0); #1;
        chk("full_same_cycle_ready", issue_ready_o, 0);
        cyc(); #1;
        chk("ready_after_retire", issue_ready_o, 1);
        do_issue(mk(3'd0, 5'd10, OPC), 4'd10, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, acc); cyc();
        foreach (exp_q[q]) ;
        set_reg(4'd6, 2'b11, 32'd6, 32'd18); set_com(4'd6, 1'b0); cyc();
        set_reg(4'd7, 2'b11, 32'd7, 32'd21); set_com(4'd7, 1'b0); cyc();
        set_reg(4'd9, 2'b11, 32'd9, 32'd27); set_com(4'd9, 1'b0); cyc();
        set_reg(4'd10, 2'b11, 32'hFFFF_FFFF, 32'd2); set_com(4'd10, 1'b0); cyc();
        wait_drain("full_drain");

        // Killed head, following result held under backpressure
        rr_mode = 2; cyc();
        do_issue(mk(3'd0, 5'd1, OPC), 4'd1, 1'b0, 32'd1, 32'd1, 1, acc); cyc();
        do_issue(mk(3'd1, 5'd2, OPC), 4'd2, 1'b0, 32'h1234, 32'h00FF, 0, acc); cyc();
        set_reg(4'd1, 2'b11, 32'd1, 32'd1); cyc();
        set_reg(4'd2, 2'b11, 32'h1234, 32'h00FF); set_com(4'd2, 1'b0); cyc();
        set_com(4'd1, 1'b1); cyc();
        n = 0;
        while (!result_valid_o && n < 20) begin cyc(); n++; end
        #1;
        chk("kill_next_valid", result_valid_o, 1);
        chk("kill_next_id", result_id_o, 2);
        repeat (3) cyc();
        #1;
        chk("held_id", result_id_o, 2);
        chk("held_data", result_data_o, 32'h12CB);
        rr_mode = 0;
        wait_drain("kill_drain");

        if (SUB_EN) begin
            do_issue(mk(3'd2, 5'd11, OPC), 4'd11, 1'b0, 32'd5, 32'd7, 0, acc); cyc();
            set_reg(4'd11, 2'b11, 32'd5, 32'd7); set_com(4'd11, 1'b0); cyc();
            chk("sub_expect", exp_q.size() == 0 ? 0 : exp_q[0].data, 32'hFFFF_FFFE);
            wait_drain("sub_drain");
        end

        // Reset with pending entries and a pending result
        rr_mode = 2; cyc();
        do_issue(mk(3'd0, 5'd12, OPC), 4'd12, 1'b0, 32'd1, 32'd2, 0, acc); cyc();
        do_issue(mk(3'd0, 5'd13, OPC), 4'd13, 1'b0, 32'd3, 32'd4, 0, acc); cyc();
        set_reg(4'd12, 2'b11, 32'd1, 32'd2); set_com(4'd12, 1'b0); cyc();
        set_reg(4'd13, 2'b11, 32'd3, 32'd4); cyc();
        #1;
        chk("pre_reset_valid", result_valid_o, 1);
        rst_i = 1'b1; exp_q.delete(); cyc();
        rst_i = 1'b0; rr_mode = 0; #1;
        chk("post_reset_valid", result_valid_o, 0);
        chk("post_reset_ready", issue_ready_o, 1);
        set_com(4'd13, 1'b0); set_reg(4'd13, 2'b11, 32'd3, 32'd4); cyc();
        repeat (3) cyc();
        #1;
        chk("stale_commit_ignored", result_valid_o, 0);

        // Randomized batches
        rr_mode = 1;
        nid = 4'd0;
        for (int bt = 0; bt < 40; bt++) begin
            items.delete(); rq.delete(); cq.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                ins = mk($urandom % 4 == 0 ? 3'($urandom) : 3'($urandom_range(0, 2)), 5'($urandom),
                         $urandom % 5 == 0 ? 7'($urandom) : OPC);
                it.id = nid; it.a = $urandom; it.b = $urandom; it.kill = $urandom % 4 == 0;
                do_issue(ins, nid, 1'($urandom), it.a, it.b, it.kill, acc);
                cyc();
                nid = nid + 4'd1;
                if (acc) items.push_back(it);
            end
            foreach (items[k]) begin
                if (!items[k].kill || $urandom % 2 == 0) begin
                    if ($urandom % 2 == 0) begin
                        r.id = items[k].id; r.a = items[k].a; r.b = items[k].b;
                        r.mask = 2'b01; rq.push_back(r);
                        r.mask = 2'b10; rq.push_back(r);
                    end else begin
                        r.id = items[k].id; r.a = items[k].a; r.b = items[k].b; r.mask = 2'b11; rq.push_back(r);
                    end
                end
                c.id = items[k].id; c.kill = items[k].kill; cq.push_back(c);
            end
            for (int k = rq.size() - 1; k > 0; k--) begin
                int j = $urandom_range(0, k);
                r = rq[k]; rq[k] = rq[j]; rq[j] = r;
            end
            for (int k = cq.size() - 1; k > 0; k--) begin
                int j = $urandom_range(0, k);
                c = cq[k]; cq[k] = cq[j]; cq[j] = c;
            end
            for (int g = 0; g < 500 && (rq.size() != 0 || cq.size() != 0); g++) begin
                if (rq.size() != 0 && $urandom % 3 != 0) begin
                    r = rq.pop_front(); set_reg(r.id, r.mask, r.a, r.b);
                end
                if (cq.size() != 0 && $urandom % 3 != 0) begin
                    c = cq.pop_front(); set_com(c.id, c.kill);
                end
                cyc();
            end
            wait_drain("rand_drain");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
